// File: rtl/booth_mult_pkg.sv
// booth_mult_pkg: shared types for the radix-4 Booth sequential multiplier.
//   state_t : controller states (IDLE, CALC, DONE)
//   digit_t : recoded Booth digit (ZERO, P1, P2, M2, M1)
//   n_dig() : Booth digits per operation for a given operand width
package booth_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    D_ZERO = 3'd0,
    D_P1   = 3'd1,
    D_P2   = 3'd2,
    D_M2   = 3'd3,
    D_M1   = 3'd4
  } digit_t;

  // One extra digit covers the sign/zero extension bits of the multiplier.
  function automatic int n_dig(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// booth_seq_mult_if: request/response bundle of the Booth multiplier.
//   master : start, signed_mode, multiplicand, multiplier out; ready, busy,
//            valid, product in
//   slave  : the multiplier side (directions mirrored)
interface booth_seq_mult_if #(
  parameter int WIDTH = 8
) ();
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 ready;
  logic                 busy;
  logic                 valid;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  ready, busy, valid, product
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output ready, busy, valid, product
  );
endinterface

// File: rtl/booth_pp_sel.sv
// booth_pp_sel: combinational radix-4 Booth partial-product selector.
//   trip : {y[2i+1], y[2i], y[2i-1]} for the current digit
//   a    : multiplicand, already sign/zero extended to WIDTH+2 bits
//   pp   : signed partial product digit*a, WIDTH+3 bits
module booth_pp_sel
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       trip,
  input  logic [WIDTH+1:0] a,
  output logic [WIDTH+2:0] pp
);
  localparam int PW = WIDTH + 3;
  localparam logic [PW-1:0] ONE = PW'(1);

  digit_t          dig;
  logic [PW-1:0]   a1, a2;

  // a is already a signed WIDTH+2 value, so one more sign bit holds 2a.
  assign a1 = {a[WIDTH+1], a};
  assign a2 = {a, 1'b0};

  always_comb begin
    dig = D_ZERO;
    unique case (trip)
      3'b001, 3'b010: dig = D_P1;
      3'b011:         dig = D_P2;
      3'b100:         dig = D_M2;
      3'b101, 3'b110: dig = D_M1;
      default:        dig = D_ZERO;
    endcase
  end

  always_comb begin
    pp = '0;
    unique case (dig)
      D_P1:    pp = a1;
      D_P2:    pp = a2;
      D_M1:    pp = (~a1) + ONE;
      D_M2:    pp = (~a2) + ONE;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-4 Booth multiplier, one digit per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : booth_seq_mult_if.slave (start/signed_mode/operands in,
//                ready/busy/valid/product out)
// Optional feature: define BOOTH_MULT_EARLY_TERM_EN to finish as soon as the
// current and all remaining Booth digits are zero.
module booth_seq_mult
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_seq_mult_if.slave bus
);
  localparam int ND = n_dig(WIDTH);
  localparam int AW = 2 * WIDTH + 4;
  localparam int CW = $clog2(ND + 1);
  localparam logic [CW-1:0] LAST    = CW'(ND - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t             state, state_nx;
  logic [WIDTH+1:0]   a_q;
  // Multiplier with y[-1] at bit 0; shifted right two bits per digit so the
  // current triplet is always y_q[2:0].
  logic [WIDTH+2:0]   y_q;
  logic [AW-1:0]      acc, acc_nx, pp_ext;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH+2:0]   pp;
  logic [WIDTH+1:0]   a_ext;
  logic [WIDTH+2:0]   y_ext;
  logic               accept, done_now;

  assign accept = bus.start && (state != S_CALC);

  assign a_ext = bus.signed_mode ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                 : {2'b00, bus.multiplicand};
  assign y_ext = bus.signed_mode ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier, 1'b0}
                                 : {2'b00, bus.multiplier, 1'b0};

  booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .trip (y_q[2:0]),
    .a    (a_q),
    .pp   (pp)
  );

  assign pp_ext = {{(AW-WIDTH-3){pp[WIDTH+2]}}, pp};
  assign acc_nx = acc + (pp_ext << {cnt, 1'b0});

`ifdef BOOTH_MULT_EARLY_TERM_EN
  // Remaining digits are all zero exactly when the remaining multiplier bits
  // (sign-filled by the shift) are all equal: only 000/111 triplets remain.
  logic zero_rest;
  assign zero_rest = (&y_q) | ~(|y_q);
  assign done_now  = (cnt == LAST) | zero_rest;
`else
  assign done_now  = (cnt == LAST);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_nx = S_CALC;
      end
      S_CALC: begin
        bus.busy = 1'b1;
        if (done_now) state_nx = S_DONE;
      end
      S_DONE: begin
        bus.ready = 1'b1;
        bus.valid = 1'b1;
        state_nx  = bus.start ? S_CALC : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      y_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      prod_q <= '0;
    end else if (accept) begin
      a_q <= a_ext;
      y_q <= y_ext;
      acc <= '0;
      cnt <= '0;
    end else if (state == S_CALC) begin
      acc <= acc_nx;
      cnt <= cnt + CNT_ONE;
      y_q <= {{2{y_q[WIDTH+2]}}, y_q[WIDTH+2:2]};
      // product only moves when the result is final
      if (done_now) prod_q <= acc_nx[2*WIDTH-1:0];
    end
  end

  assign bus.product = prod_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: bench for booth_seq_mult at WIDTH=8 and WIDTH=16.
// Expected products come from plain integer multiplication; expected latency
// from the Booth digit values of the multiplier.
module tb_booth_seq_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_seq_mult_if #(.WIDTH(8))  bus8 ();
  booth_seq_mult_if #(.WIDTH(16)) bus16 ();

  booth_seq_mult #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  booth_seq_mult #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          w;
    logic        sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    int          lat;   // -1: take latency from the model
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic sm,
                       input logic [15:0] a, input logic [15:0] b);
    if (w == 8) begin
      bus8.start = st; bus8.signed_mode = sm;
      bus8.multiplicand = a[7:0]; bus8.multiplier = b[7:0];
    end else begin
      bus16.start = st; bus16.signed_mode = sm;
      bus16.multiplicand = a; bus16.multiplier = b;
    end
  endtask

  function automatic logic rd_valid(input int w);
    return (w == 8) ? bus8.valid : bus16.valid;
  endfunction
  function automatic logic rd_ready(input int w);
    return (w == 8) ? bus8.ready : bus16.ready;
  endfunction
  function automatic logic [31:0] rd_prod(input int w);
    return (w == 8) ? {16'h0, bus8.product} : bus16.product;
  endfunction

  function automatic longint opval(input int w, input logic sm, input logic [15:0] x);
    if (w == 8) return sm ? longint'($signed(x[7:0])) : longint'(x[7:0]);
    return sm ? longint'($signed(x)) : longint'(x);
  endfunction

  function automatic logic [31:0] ref_prod(input int w, input logic sm,
                                           input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = opval(w, sm, a) * opval(w, sm, b);
    return (w == 8) ? {16'h0, p[15:0]} : p[31:0];
  endfunction

  // Accept-to-valid latency counted in clock edges, accepting edge included.
  function automatic int ref_lat(input int w, input logic sm, input logic [15:0] b);
    longint yv;
    int nd, hi, d, b0, b1, bm;
    yv = opval(w, sm, b);
    nd = w / 2 + 1;
    hi = -1;
    for (int i = 0; i < nd; i++) begin
      b1 = int'((yv >>> (2*i+1)) & 64'd1);
      b0 = int'((yv >>> (2*i)) & 64'd1);
      bm = (i == 0) ? 0 : int'((yv >>> (2*i-1)) & 64'd1);
      d  = -2*b1 + b0 + bm;
      if (d != 0) hi = i;
    end
`ifdef BOOTH_MULT_EARLY_TERM_EN
    return ((hi + 1 < nd - 1) ? hi + 1 : nd - 1) + 2;
`else
    return nd + 1 + 0 * hi;
`endif
  endfunction

  // One full operation: start presented for one edge, inputs scrambled after.
  task automatic run_op(input int w, input logic sm, input logic [15:0] a,
                        input logic [15:0] b, output logic [31:0] prod, output int lat);
    @(negedge clk);
    chk("ready_before_start", 32'(rd_ready(w)), 32'd1);
    drive(w, 1'b1, sm, a, b);
    @(negedge clk);
    drive(w, 1'b0, ~sm, 16'($urandom), 16'($urandom));
    lat = 1;
    while (!rd_valid(w) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    prod = rd_prod(w);
    @(negedge clk);
    chk("valid_single_pulse", 32'(rd_valid(w)), 32'd0);
  endtask

  initial begin
    logic [31:0] prod;
    int          lat, n, exp_lat, pulses;
    int          w;
    logic        sm;
    logic [15:0] a, b;

    vt[0]  = '{8,  1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01, -1};
    vt[1]  = '{8,  1'b1, 16'h0080, 16'h0080, 32'h00004000, -1};
    vt[2]  = '{8,  1'b1, 16'h0080, 16'h007F, 32'h0000C080, -1};
    vt[3]  = '{8,  1'b0, 16'h0080, 16'h007F, 32'h00003F80, -1};
`ifdef BOOTH_MULT_EARLY_TERM_EN
    vt[4]  = '{8,  1'b0, 16'h00AB, 16'h0000, 32'h00000000, 2};
`else
    vt[4]  = '{8,  1'b0, 16'h00AB, 16'h0000, 32'h00000000, 6};
`endif
    vt[5]  = '{8,  1'b1, 16'h00FF, 16'h00FF, 32'h00000001, -1};
    vt[6]  = '{8,  1'b1, 16'h007F, 16'h007F, 32'h00003F01, -1};
    vt[7]  = '{8,  1'b0, 16'h0003, 16'h0005, 32'h0000000F, -1};
    vt[8]  = '{8,  1'b1, 16'h0005, 16'h00FD, 32'h0000FFF1, -1};
    vt[9]  = '{16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, -1};
    vt[10] = '{16, 1'b1, 16'h8000, 16'h8000, 32'h40000000, -1};
    vt[11] = '{16, 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, -1};

    drive(8, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(16, 1'b0, 1'b0, 16'h0, 16'h0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready8",   32'(bus8.ready), 32'd1);
    chk("rst_busy8",    32'(bus8.busy),  32'd0);
    chk("rst_valid8",   32'(bus8.valid), 32'd0);
    chk("rst_product8", 32'(bus8.product), 32'd0);
    chk("rst_ready16",  32'(bus16.ready), 32'd1);
    chk("rst_product16", bus16.product, 32'd0);
    rst_n = 1'b1;

    // directed table
    foreach (vt[i]) begin
      run_op(vt[i].w, vt[i].sm, vt[i].a, vt[i].b, prod, lat);
      exp_lat = (vt[i].lat < 0) ? ref_lat(vt[i].w, vt[i].sm, vt[i].b) : vt[i].lat;
      chk($sformatf("vec%0d_product", i), prod, vt[i].p);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat));
    end

    // start held through CALC is ignored; start in DONE chains 3*5
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 16'h00FF, 16'h00FF);
    @(negedge clk);
    n = 1;
    while (!bus8.valid && n < 40) begin
      drive(8, 1'b1, 1'b1, 16'h0011, 16'h0022);
      @(negedge clk);
      n++;
    end
    chk("b2b_first_latency", 32'(n), 32'(ref_lat(8, 1'b0, 16'h00FF)));
    chk("b2b_first_product", 32'(bus8.product), 32'h0000FE01);
    drive(8, 1'b1, 1'b0, 16'h0003, 16'h0005);
    @(negedge clk);
    chk("b2b_no_idle_busy", 32'(bus8.busy), 32'd1);
    drive(8, 1'b0, 1'b0, 16'h00EE, 16'h00DD);
    n = 1;
    while (!bus8.valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second_latency", 32'(n), 32'(ref_lat(8, 1'b0, 16'h0005)));
    chk("b2b_second_product", 32'(bus8.product), 32'h0000000F);
    @(negedge clk);

    // reset on the third CALC cycle aborts the operation
    drive(8, 1'b1, 1'b0, 16'h00FF, 16'h00FF);
    @(negedge clk);
    drive(8, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready",   32'(bus8.ready), 32'd1);
    chk("abort_busy",    32'(bus8.busy),  32'd0);
    chk("abort_valid",   32'(bus8.valid), 32'd0);
    chk("abort_product", 32'(bus8.product), 32'd0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus8.valid) pulses++;
    end
    chk("abort_no_valid", 32'(pulses), 32'd0);
    run_op(8, 1'b0, 16'h0007, 16'h0009, prod, lat);
    chk("after_abort_product", prod, 32'h0000003F);
    chk("after_abort_latency", 32'(lat), 32'(ref_lat(8, 1'b0, 16'h0009)));

    // random operands, both widths and both modes
    for (int k = 0; k < 60; k++) begin
      w  = (k % 2 == 0) ? 8 : 16;
      sm = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (k % 5 == 0) b = b & 16'h000F;
      if (k % 11 == 0) b = 16'h0;
      if (k % 13 == 0) b = 16'hFFFF;
      run_op(w, sm, a, b, prod, lat);
      chk($sformatf("rnd%0d_w%0d_product", k, w), prod, ref_prod(w, sm, a, b));
      chk($sformatf("rnd%0d_w%0d_latency", k, w), 32'(lat), 32'(ref_lat(w, sm, b)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be even and >= 4.
REQ-002 Derived constant N_DIG = WIDTH/2 + 1 SHALL be the number of radix-4 Booth digits per operation.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  request to begin an operation; sampled only while ready=1.
REQ-007 signed_mode  input  1  1 = both operands two's complement, 0 = both unsigned; sampled with start.
REQ-008 multiplicand  input  WIDTH  operand A; sampled with start.
REQ-009 multiplier  input  WIDTH  operand B; sampled with start.
REQ-010 ready  output  1  high in IDLE and DONE; the block can accept start.
REQ-011 busy  output  1  high in CALC.
REQ-012 valid  output  1  one-cycle pulse, high only in DONE.
REQ-013 product  output  2*WIDTH  result; registered; stable from DONE until the next accepted start.

Function
REQ-014 FSM states SHALL be IDLE, CALC and DONE.
REQ-015 Accept: start=1 while ready=1 SHALL latch the operands and signed_mode, clear the accumulator and digit counter, and enter CALC.
REQ-016 Operand extension: multiplier SHALL be extended to WIDTH+2 bits and multiplicand to WIDTH+2 bits, with sign bits if signed_mode=1, else zeros; an implicit y[-1]=0 SHALL be used.
REQ-017 Digit i SHALL be selected by triplet {y[2i+1],y[2i],y[2i-1]}: 000->0, 001->+A, 010->+A, 011->+2A, 100->-2A, 101->-A, 110->-A, 111->0.
REQ-018 CALC SHALL process exactly one digit per cycle, adding digit*A*4^i into an accumulator of 2*WIDTH+4 bits; negation SHALL be two's complement.
REQ-019 After digit N_DIG-1 the FSM SHALL enter DONE; product SHALL be the low 2*WIDTH bits of the accumulator, exact for both modes.
REQ-020 Latency: valid SHALL be high exactly N_DIG+1 cycles after the accepting edge (6 for WIDTH=8), without early termination.
REQ-021 DONE SHALL last one cycle: start=1 in DONE SHALL be accepted and lead to CALC (back-to-back); otherwise the FSM SHALL go to IDLE.
REQ-022 start in CALC SHALL be ignored and SHALL have no effect on the operation in progress.
REQ-023 Input changes outside the accepting cycle SHALL NOT affect the result.

Reset
REQ-024 With rst_n=0 at a clock edge: state IDLE; ready=1, busy=0, valid=0, product=0; accumulator and counter cleared.
REQ-025 Reset during CALC or DONE SHALL abort the operation, with no valid pulse.

Configuration
REQ-026 Macro BOOTH_MULT_EARLY_TERM_EN: when defined, in CALC, if the current and all remaining digits encode 0, the FSM SHALL go directly to DONE after the current cycle; the product SHALL be identical to the non-early-terminated result.
REQ-027 Without BOOTH_MULT_EARLY_TERM_EN, latency SHALL always be N_DIG+1 cycles; with it, minimum latency SHALL be 2 cycles.

Structure
REQ-028 Package booth_mult_pkg SHALL hold the FSM state enum, the Booth digit encoding type (ZERO, P1, P2, M2, M1) and the N_DIG function.
REQ-029 Sub-module booth_pp_sel (combinational, parametrised on WIDTH) SHALL decode a triplet and produce the signed WIDTH+3-bit partial product; booth_seq_mult SHALL instantiate it once.

Verification
REQ-030 WIDTH=8, unsigned, 0xFF*0xFF -> product=0xFE01, valid 6 cycles after accept, single-cycle pulse.
REQ-031 Signed, 0x80*0x80 (-128*-128) -> 0x4000; signed 0x80*0x7F -> 0xC080; unsigned 0x80*0x7F -> 0x3F80.
REQ-032 Start asserted in every CALC cycle -> ignored; start in the DONE cycle with 3*5 -> next valid gives 0x000F, with no IDLE cycle between.
REQ-033 rst_n=0 on the third CALC cycle -> next cycle ready=1, busy=0, product=0, no valid pulse; a following 7*9 -> 0x003F.
REQ-034 Multiplier 0x00, multiplicand 0xAB: with BOOTH_MULT_EARLY_TERM_EN -> valid after 2 cycles, product 0; without it -> valid after 6 cycles, product 0.
REQ-035 Random signed and unsigned operands for WIDTH=8 and WIDTH=16, checked against a reference model, with both macro settings.
